// File: rtl/eth_fifo_pkg.sv
// eth_fifo_pkg: shared helpers for the eth_fifo descriptor/datapath queue.
package eth_fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Capacity is bounded by the count width so cnt can never wrap.
    function automatic int cap_f(input int depth, input int cnt_width);
        int m;
        m = (1 << cnt_width) - 1;
        return (depth < m) ? depth : m;
    endfunction

endpackage

// File: rtl/eth_fifo_mem.sv
// eth_fifo_mem: simple dual-port array, synchronous write, asynchronous read.
module eth_fifo_mem
    import eth_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AW         = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/eth_fifo.sv
// eth_fifo: single-clock first-word-fall-through FIFO with level flags.
// Define ETH_FIFO_ASSERT_EN to compile overflow/underflow/count simulation checks.
module eth_fifo
    import eth_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write,
    input  logic                  read,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  empty,
    output logic [CNT_WIDTH-1:0]  cnt
);

    localparam int AW  = clog2(DEPTH);
    localparam int CAP = cap_f(DEPTH, CNT_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CAP_C   = CNT_WIDTH'(CAP);
    localparam logic [CNT_WIDTH-1:0] CAP_M1  = CNT_WIDTH'(CAP - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [AW-1:0]        PTR_ONE = AW'(1);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  wr_en, rd_en, mem_we;
    logic [AW-1:0]         mem_waddr;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign full         = cnt_q == CAP_C;
    assign almost_full  = cnt_q == CAP_M1;
    assign almost_empty = cnt_q == CNT_ONE;
    assign empty        = cnt_q == '0;
    assign cnt          = cnt_q;

    // A write into a full FIFO is accepted only when a pop frees the slot.
    assign wr_en = write & (~full | read);
    assign rd_en = read & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = write ? PTR_ONE : '0;
            cnt_d    = write ? CNT_ONE : '0;
        end else begin
            wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
            rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
            cnt_d    = (wr_en & ~rd_en) ? cnt_q + CNT_ONE :
                       (rd_en & ~wr_en) ? cnt_q - CNT_ONE : cnt_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Clear with write lands the new entry at slot 0.
    assign mem_we    = clear ? write : wr_en;
    assign mem_waddr = clear ? '0 : wr_ptr_q;

    eth_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (data_in),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    assign data_out = empty ? '0 : mem_rdata;

`ifdef ETH_FIFO_ASSERT_EN
    always_ff @(posedge clk) begin
        if (!reset && !clear) begin
            if (write && full && !read) $error("eth_fifo: write while full");
            if (read && empty) $error("eth_fifo: read while empty");
        end
        if (!reset && cnt_q > CAP_C) $error("eth_fifo: cnt %0d exceeds capacity %0d", cnt_q, CAP);
    end
`else
`endif

endmodule

// File: tb/tb_eth_fifo.sv
// tb_eth_fifo: directed self-checking bench for eth_fifo (DEPTH=32, CNT_WIDTH=5, capacity 31).
module tb_eth_fifo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_in = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] data_out;
    logic        full, almost_full, almost_empty, empty;
    logic [4:0]  cnt;

    int n_assert = 0;
    int n_fail = 0;
    logic [31:0] q[$];

    eth_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (32),
        .CNT_WIDTH  (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .write        (write),
        .read         (read),
        .clear        (clear),
        .data_out     (data_out),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .empty        (empty),
        .cnt          (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input int c, input logic [31:0] d);
        chk({tag, ".cnt"}, 32'(cnt), 32'(c));
        chk({tag, ".data_out"}, data_out, d);
        chk({tag, ".empty"}, 32'(empty), 32'(c == 0));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(c == 1));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(c == 30));
        chk({tag, ".full"}, 32'(full), 32'(c == 31));
    endtask

    // Apply one cycle of inputs, sample 1 time unit after the edge.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [31:0] d);
        write = w;
        read = r;
        clear = c;
        data_in = d;
        @(posedge clk);
        #1;
        write = 1'b0;
        read = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        // Power-on reset
        #2;
        chk_state("por", 0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset mid-fill takes effect before the next edge
        cyc(1, 0, 0, 32'hA1);
        cyc(1, 0, 0, 32'hA2);
        cyc(1, 0, 0, 32'hA3);
        chk_state("prefill", 3, 32'hA1);
        #2;
        reset = 1'b1;
        #1;
        chk_state("async_reset", 0, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_state("after_reset", 0, 32'h0);

        // Basic ordering
        cyc(1, 0, 0, 32'h11);
        chk_state("w11", 1, 32'h11);
        cyc(1, 0, 0, 32'h22);
        cyc(1, 0, 0, 32'h33);
        chk_state("w33", 3, 32'h11);
        cyc(0, 1, 0, 32'h0);
        chk_state("r1", 2, 32'h22);
        cyc(0, 1, 0, 32'h0);
        chk_state("r2", 1, 32'h33);
        cyc(0, 1, 0, 32'h0);
        chk_state("r3", 0, 32'h0);

        // Fill to capacity
        for (int i = 0; i < 31; i++) begin
            cyc(1, 0, 0, 32'h100 + 32'(i));
            if (i == 29) chk_state("fill30", 30, 32'h100);
        end
        chk_state("fill31", 31, 32'h100);
        cyc(1, 0, 0, 32'hDEAD);
        chk_state("overflow", 31, 32'h100);
        cyc(1, 1, 0, 32'hBEEF);
        chk_state("full_rw", 31, 32'h101);
        for (int i = 0; i < 31; i++) begin
            chk("drain", data_out, (i == 30) ? 32'hBEEF : 32'h101 + 32'(i));
            cyc(0, 1, 0, 32'h0);
        end
        chk_state("drained", 0, 32'h0);

        // Empty corner cases
        cyc(0, 1, 0, 32'h0);
        chk_state("underflow", 0, 32'h0);
        cyc(1, 1, 0, 32'h55);
        chk_state("empty_rw", 1, 32'h55);
        cyc(0, 1, 0, 32'h0);
        chk_state("pop55", 0, 32'h0);

        // Clear
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 32'h60 + 32'(i));
        chk_state("five", 5, 32'h60);
        cyc(0, 0, 1, 32'h0);
        chk_state("clear", 0, 32'h0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'h70 + 32'(i));
        cyc(1, 1, 1, 32'hAB);
        chk_state("clear_w", 1, 32'hAB);
        cyc(1, 0, 0, 32'hAC);
        chk_state("after_clear_w", 2, 32'hAB);
        cyc(0, 1, 0, 32'h0);
        chk_state("pop_ab", 1, 32'hAC);
        cyc(0, 1, 0, 32'h0);
        chk_state("pop_ac", 0, 32'h0);

        // Random interleaving against a queue model; biased to fill then drain
        for (int i = 0; i < 100; i++) begin
            logic w, r, we, re;
            logic [31:0] d;
            w = (i < 50) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            r = (i < 50) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            d = $urandom;
            we = w && (q.size() < 31 || r);
            re = r && q.size() > 0;
            if (re) void'(q.pop_front());
            if (we) q.push_back(d);
            cyc(w, r, 0, d);
            chk("rand.cnt", 32'(cnt), 32'(q.size()));
            chk("rand.data", data_out, (q.size() > 0) ? q[0] : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_fifo.md
# eth_fifo

Synchronous single-clock first-word-fall-through FIFO used as the frame-descriptor queue of the switch's dequeue-pointer logic and as generic buffering in the MAC datapath. The producer pushes with `write`, the consumer sees the head entry on `data_out` and pops with `read`. Occupancy and level flags drive the consumer's state machine.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: entry width in bits.
- `DEPTH`, default 8: storage entries; must be a power of two ≥ 2.
- `CNT_WIDTH`, default 4: width of `cnt`.

Ports:
- `clk`, input, 1: clock, rising edge.
- `reset`, input, 1: reset, asynchronous, active-high.
- `data_in`, input, `DATA_WIDTH`: write data.
- `write`, input, 1: push request.
- `read`, input, 1: pop request.
- `clear`, input, 1: synchronous flush.
- `data_out`, output, `DATA_WIDTH`: head entry; 0 when empty.
- `full`, output, 1: `cnt == CAP`.
- `almost_full`, output, 1: `cnt == CAP-1`.
- `almost_empty`, output, 1: `cnt == 1`.
- `empty`, output, 1: `cnt == 0`.
- `cnt`, output, `CNT_WIDTH`: number of stored entries.

## Operation
- Capacity is `CAP = min(DEPTH, 2^CNT_WIDTH − 1)`, so `cnt` never wraps. For example, `DEPTH=32, CNT_WIDTH=5` gives `CAP=31`.
- Storage is a `DEPTH` × `DATA_WIDTH` array with `log2(DEPTH)`-bit read and write pointers. Both pointers wrap modulo `DEPTH`.
- Effective write: `write & ~full`, or `write & full & read`.
- Effective read: `read & ~empty`.
- Write when full without read: ignored; no state change.
- Read when empty: ignored. A simultaneous read and write on an empty FIFO performs only the write.
- Simultaneous effective read and write: both pointers advance and `cnt` is unchanged.
- `cnt` increments on a write-only cycle and decrements on a read-only cycle.
- `clear` has priority over read and write:
  - Both pointers return to 0.
  - If `write` is also high, `data_in` is stored at entry 0 and `cnt` becomes 1.
  - Otherwise `cnt` becomes 0.
  - `read` is ignored during `clear`.
- `data_out` = `mem[rd_ptr]` when `cnt != 0`, else all zeros (combinational, first-word fall-through).
- All flags decode combinationally from `cnt`.
- Storage array is not reset.

## Timing
- Reset (asynchronous, any time, including mid-operation): pointers and `cnt` go to 0.
  - Outputs then read `empty=1`, `almost_empty=0`, `almost_full=0`, `full=0`, `cnt=0`, `data_out=0`.
- Write latency: data written at edge N is visible on `data_out` after edge N when the FIFO was empty. Flags and `cnt` update at that same edge.
- Read: the pop happens at the edge where `read` is sampled high. The next entry (or 0 if empty) appears immediately after that edge.
- A `read` held high for k cycles pops k entries; no handshake beyond level sampling.

## Configuration
- `ETH_FIFO_ASSERT_EN` defined: simulation checks report `$error` on any of:
  - write while full without read;
  - read while empty;
  - `cnt` exceeding `CAP`.
- `ETH_FIFO_ASSERT_EN` undefined: no checks compiled. Overflow and underflow are silently ignored as specified above.
- Functional behaviour is identical either way.

## Structure
- Package `eth_fifo_pkg`:
  - `clog2` helper function;
  - `cap_f(DEPTH, CNT_WIDTH)` capacity function.
- Sub-module `eth_fifo_mem`: simple dual-port array with synchronous write and asynchronous read, parameterised by `DATA_WIDTH` and `DEPTH`.
- Pointer, count and flag logic stays in `eth_fifo`.

## Test plan
- Reset mid-fill (3 entries, `DATA_WIDTH=32`, `DEPTH=32`, `CNT_WIDTH=5`) → `cnt=0`, `empty=1`, `data_out=0` immediately, before the next clock edge.
- Write `0x11`, `0x22`, `0x33` → `data_out=0x11` after the first edge, `cnt=3`. Then three reads return `0x11`, `0x22`, `0x33` in order, then `empty=1`, `data_out=0`.
- Fill to 31 entries → `full=1`, `almost_full` high at 30. A 32nd write is ignored and `cnt` stays 31. Write and read together while full → `cnt` stays 31 and the head advances.
- Read on empty → `cnt` stays 0. Read and write together on empty → `cnt=1`, `data_out=data_in`.
- With 5 entries, assert `clear` → `cnt=0`. Assert `clear` with `write` of `0xAB` → `cnt=1`, `data_out=0xAB`, `almost_empty=1`.
- Pointer wrap: run 100 interleaved writes and reads with random occupancy between 0 and 31 → data order is preserved and `cnt` matches a reference model every cycle.
